// File: rtl/rv_pkg.sv
// Shared constants and helpers for the integer register file slice.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

    // Architectural register that is hardwired to zero.
    localparam int X0 = 0;

    // Address width for an array of n entries; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit and producer tag per architectural
// register. Issue marks a register busy, a writeback whose tag matches the
// recorded producer clears it, flush drops everything. Read-side lookups mask
// busy when a matching writeback is on the bus in the same cycle.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int AW    = addr_width(NREG_DEF),
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_valid_i,
    input  logic [AW-1:0]      iss_addr_i,
    input  logic [TAG_W-1:0]   iss_tag_i,
    input  logic [NWR-1:0]     wb_valid_i,
    input  logic [NWR*AW-1:0]  wb_addr_i,
    input  logic [NWR*TAG_W-1:0] wb_tag_i,
    input  logic               flush_i,
    input  logic [NRD-1:0]     rd_en_i,
    input  logic [NRD*AW-1:0]  rd_addr_i,
    output logic [NRD-1:0]     rd_busy_o,
    output logic [NRD*TAG_W-1:0] rd_tag_o
);

    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q [NREG];
    logic [TAG_W-1:0] tag_d [NREG];

    // Next busy/tag state: clear on matching writeback, then issue overrides
    // the clear, then flush overrides everything (including a same-cycle issue).
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int k = 0; k < NWR; k++) begin
            if (wb_valid_i[k]
                && (wb_addr_i[k*AW +: AW] != AW'(X0))
                && busy_q[wb_addr_i[k*AW +: AW]]
                && (tag_q[wb_addr_i[k*AW +: AW]] == wb_tag_i[k*TAG_W +: TAG_W])) begin
                busy_d[wb_addr_i[k*AW +: AW]] = 1'b0;
                tag_d[wb_addr_i[k*AW +: AW]]  = '0;
            end
        end
        if (iss_valid_i && (iss_addr_i != AW'(X0))) begin
            busy_d[iss_addr_i] = 1'b1;
            tag_d[iss_addr_i]  = iss_tag_i;
        end
        if (flush_i) begin
            busy_d = '0;
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = '0;
            end
        end
        busy_d[X0] = 1'b0;
        tag_d[X0]  = '0;
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    // Per-port operand lookup; a writeback carrying the recorded producer tag
    // this cycle means the operand is already available through the bypass.
    always_comb begin
        rd_busy_o = '0;
        rd_tag_o  = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_en_i[k] && (rd_addr_i[k*AW +: AW] != AW'(X0))) begin
                rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
                for (int j = 0; j < NWR; j++) begin
                    if (wb_valid_i[j]
                        && (wb_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW])
                        && (wb_tag_i[j*TAG_W +: TAG_W] == tag_q[rd_addr_i[k*AW +: AW]])) begin
                        rd_busy_o[k] = 1'b0;
                    end
                end
                if (rd_busy_o[k]) begin
                    rd_tag_o[k*TAG_W +: TAG_W] = tag_q[rd_addr_i[k*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with writeback bypass and an attached
// pending-write scoreboard. Data array, bypass muxes and the debug read
// register live here; hazard tracking is in regfile_scoreboard.
module regfile_sb
    import rv_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREG  = NREG_DEF,
    parameter  int NRD   = 2,
    parameter  int NWR   = 2,
    parameter  int TAG_W = TAG_W_DEF,
    localparam int AW    = addr_width(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD-1:0]        rd_en_i,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    output logic [NRD*TAG_W-1:0]  rd_tag_o,
    input  logic                  iss_valid_i,
    input  logic [AW-1:0]         iss_addr_i,
    input  logic [TAG_W-1:0]      iss_tag_i,
    input  logic [NWR-1:0]        wb_valid_i,
    input  logic [NWR*AW-1:0]     wb_addr_i,
    input  logic [NWR*TAG_W-1:0]  wb_tag_i,
    input  logic [NWR*XLEN-1:0]   wb_data_i,
    input  logic                  flush_i,
    input  logic [AW-1:0]         dbg_addr_i,
    output logic [XLEN-1:0]       dbg_data_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Data array write; later ports overwrite earlier ones on an address clash.
    // Tags play no part here, so stale writebacks still land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wb_valid_i[k] && (wb_addr_i[k*AW +: AW] != AW'(X0))) begin
                    regs_q[wb_addr_i[k*AW +: AW]] <= wb_data_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Read data with same-cycle writeback bypass, highest-index port first.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_en_i[k] && (rd_addr_i[k*AW +: AW] != AW'(X0))) begin
                rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
                for (int j = 0; j < NWR; j++) begin
                    if (wb_valid_i[j] && (wb_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW])) begin
                        rd_data_o[k*XLEN +: XLEN] = wb_data_i[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Debug port returns the array contents before this edge's writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data_o <= XLEN'(ZERO_WORD);
        end else if (dbg_addr_i == AW'(X0)) begin
            dbg_data_o <= XLEN'(ZERO_WORD);
        end else begin
            dbg_data_o <= regs_q[dbg_addr_i];
        end
    end

    regfile_scoreboard #(
        .NREG  (NREG),
        .AW    (AW),
        .NRD   (NRD),
        .NWR   (NWR),
        .TAG_W (TAG_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid_i (iss_valid_i),
        .iss_addr_i  (iss_addr_i),
        .iss_tag_i   (iss_tag_i),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .wb_tag_i    (wb_tag_i),
        .flush_i     (flush_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_busy_o   (rd_busy_o),
        .rd_tag_o    (rd_tag_o)
    );

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with an integrated write scoreboard for the RISC-V core. It supplies NRD combinational read ports with same-cycle writeback bypass, accepts NWR writeback ports, and tracks pending writes per architectural register with a tag so decode can detect RAW hazards without a separate dependency unit. It sits between decode/issue (read and issue side) and the writeback stage (write side).

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers; AW = clog2(NREG)
- NRD, 2, read ports
- NWR, 2, writeback ports
- TAG_W, 4, producer tag width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_en_i  in  NRD  per-port read enable
- rd_addr_i  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data
- rd_busy_o  out  NRD  1 = operand has an outstanding producer, data not valid
- rd_tag_o  out  NRD*TAG_W  tag of outstanding producer (0 when not busy)
- iss_valid_i  in  1  issue of an instruction that writes a register
- iss_addr_i  in  AW  destination register of issued instruction
- iss_tag_i  in  TAG_W  tag of issued instruction
- wb_valid_i  in  NWR  writeback valid per port
- wb_addr_i  in  NWR*AW  writeback destination
- wb_tag_i  in  NWR*TAG_W  writeback producer tag
- wb_data_i  in  NWR*XLEN  writeback data
- flush_i  in  1  clear all pending-write state
- dbg_addr_i  in  AW  debug read address
- dbg_data_o  out  XLEN  registered debug read data

## Operation
- State: regs[NREG], busy[NREG], tag[NREG]. Register 0 hardwired: never written, never busy, reads 0.
- Write: each wb port k with wb_valid_i[k] and addr != 0 writes regs[addr]. Two ports to same addr in one cycle: highest index port wins.
- Write is unconditional on tag (stale writebacks still update regs); tag only governs busy clearing.
- Busy clear: wb port k clears busy[a] iff busy[a] and tag[a] == wb_tag_i[k].
- Busy set: iss_valid_i with iss_addr_i != 0 sets busy[iss_addr_i] = 1, tag = iss_tag_i. Issue to x0 ignored.
- Same cycle issue and clearing writeback to same addr: issue wins (busy stays 1, new tag).
- flush_i: all busy and tag cleared next edge; writebacks in that cycle still commit; issue in same cycle is ignored.
- Read port k, rd_en_i[k]=0: data 0, busy 0, tag 0.
- Read addr 0: data 0, busy 0, tag 0.
- Otherwise data = wb_data of highest-index valid wb port targeting addr, else regs[addr]. busy = busy[addr] and no valid wb port targets addr with tag matching tag[addr]. tag_o = tag[addr] when busy_o, else 0.
- Debug: dbg_data_o <= regs[dbg_addr_i] each edge (pre-write value; 0 for addr 0).

## Timing
- Reset (rst_n low, asynchronous): regs, busy, tag all 0; dbg_data_o = 0. Read outputs follow combinational rules with zeroed state. Release synchronous to clk by integrator.
- Read latency 0 cycles (combinational from rd_* and wb_* inputs).
- Writeback visible on read ports in same cycle via bypass, from array from next cycle.
- Issue: busy visible on reads from the cycle after iss_valid_i; no same-cycle forwarding of issue.
- Flush: reads show not-busy from the cycle after flush_i.
- Reset asserted mid-operation discards all pending state; no writeback after reset release affects busy.
- dbg_data_o: 1-cycle latency.

## Structure
- Shared package rv_pkg: XLEN default, ZERO_WORD, X0 address constant, tag type width default, AW derivation function.
- Sub-module regfile_scoreboard: busy/tag arrays, set/clear/flush priority, per-port busy/tag lookup with writeback-match masking. Top holds data array, bypass muxes, debug register.

## Test plan
- Reset then read x5 on both ports -> data 0, busy 0; dbg_data_o 0.
- Issue x3 tag 2; next cycle read x3 -> busy 1, tag 2; wb x3 tag 2 data 0xDEADBEEF same cycle -> data 0xDEADBEEF, busy 0; following cycle busy 0 from array.
- Issue x4 tag 1, then issue x4 tag 3; wb x4 tag 1 data 0x11 -> regs x4 = 0x11 but busy stays 1 with tag 3; wb tag 3 data 0x33 clears it.
- wb ports 0 and 1 both write x7 (0xAAAA, 0xBBBB) -> read x7 same cycle and next cycle returns 0xBBBB.
- Issue x8 tag 5 same cycle as wb x8 tag (current) -> busy 1, tag 5 next cycle; flush_i -> all reads busy 0 next cycle.
- Write x0 with 0xFFFFFFFF and issue x0 -> reads of x0 return 0, busy 0; assert rst_n low mid-stream with busy entries -> immediately all state 0.
